wb_unit: RTL and testbench

- Write-back stage for the MIPS core: the producer end of the register-file write port that the ID stage consumes (Wen/Waddr/Wdata).
- Takes a retiring instruction word and its ALU result, decodes the destination register, and for lw waits on a variable-latency load response.
- Emits a single-cycle register-file write pulse per writing instruction, plus a load-timeout error pulse and a retired-instruction counter.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/wb_unit_if.sv | 33 +++
 rtl/wb_dest_decode.sv | 38 +++
 rtl/wb_unit.sv | 121 ++++++++++++
 tb/tb_wb_unit.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the write-back slice: opcodes, instruction field
// positions and the write-back FSM state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic       writes;
    logic       is_load;
    logic [4:0] dest;
  } dest_info_t;

endpackage

// File: rtl/wb_unit_if.sv
// Bus bundle between the retiring pipeline / load port (master) and the
// write-back unit (slave), including the register-file write port.
interface wb_unit_if #(
  parameter int CNT_W = 16
) ();
  import mips_pkg::*;

  // Instruction handshake: a transfer happens on a rising CLK edge where
  // In_valid && In_ready; Ins/Alu_res must be stable during that cycle.
  logic             In_valid;
  logic             In_ready;
  logic [31:0]      Ins;
  logic [31:0]      Alu_res;
  logic             Ld_valid;
  logic [31:0]      Ld_data;
  logic             Wen;
  logic [4:0]       Waddr;
  logic [31:0]      Wdata;
  logic             Ld_err;
  logic [CNT_W-1:0] Retired;
  wb_state_e        state;

  modport master (
    output In_valid, Ins, Alu_res, Ld_valid, Ld_data,
    input  In_ready, Wen, Waddr, Wdata, Ld_err, Retired, state
  );

  modport slave (
    input  In_valid, Ins, Alu_res, Ld_valid, Ld_data,
    output In_ready, Wen, Waddr, Wdata, Ld_err, Retired, state
  );

endinterface

// File: rtl/wb_dest_decode.sv
// Combinational destination decode of a MIPS instruction word; also usable by
// hazard logic to learn which register an instruction will write.
module wb_dest_decode
  import mips_pkg::*;
(
  input  logic [31:0] ins,
  output dest_info_t  info
);

  logic [5:0] op;
  logic       unused_bits;

  assign op          = ins[OP_MSB:OP_LSB];
  assign unused_bits = ^{ins[25:21], ins[10:0]};

  always_comb begin
    info = '0;
    case (op)
      OP_RTYPE: begin
        info.writes = 1'b1;
        info.dest   = ins[RD_MSB:RD_LSB];
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: begin
        info.writes = 1'b1;
        info.dest   = ins[RT_MSB:RT_LSB];
      end
      OP_LW: begin
        info.writes  = 1'b1;
        info.is_load = 1'b1;
        info.dest    = ins[RT_MSB:RT_LSB];
      end
      default: ;
    endcase
    // $0 is hard-wired, so a write to it is no write at all.
    if (info.dest == 5'd0) info.writes = 1'b0;
  end

endmodule

// File: rtl/wb_unit.sv
// Write-back stage: turns retiring instructions (and lw load responses) into
// single-cycle register-file write pulses, with load timeout and retire count.
module wb_unit
  import mips_pkg::*;
#(
  parameter int LD_TIMEOUT = 16,
  parameter int CNT_W      = 16
) (
  input  logic     CLK,
  input  logic     RST,
  wb_unit_if.slave bus
);

  localparam int                WAIT_W    = $clog2(LD_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LD_TIMEOUT - 1);

  dest_info_t        dec;
  logic              in_ready;
  logic              accept;

  wb_state_e         state_q,   state_d;
  logic [WAIT_W-1:0] cnt_q,     cnt_d;
  logic [4:0]        dest_q,    dest_d;
  logic              wr_q,      wr_d;
  logic              wen_q,     wen_d;
  logic [4:0]        waddr_q,   waddr_d;
  logic [31:0]       wdata_q,   wdata_d;
  logic              err_q,     err_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  wb_dest_decode u_dec (
    .ins  (bus.Ins),
    .info (dec)
  );

  assign in_ready = RST && (state_q == IDLE);
  assign accept   = bus.In_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dest_d    = dest_q;
    wr_d      = wr_q;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    err_d     = 1'b0;
    retired_d = retired_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec.is_load) begin
            state_d = LOAD_WAIT;
            cnt_d   = '0;
            dest_d  = dec.dest;
            wr_d    = dec.writes;
          end else begin
            retired_d = retired_q + CNT_W'(1);
            if (dec.writes) begin
              wen_d   = 1'b1;
              waddr_d = dec.dest;
              wdata_d = bus.Alu_res;
            end
          end
        end
      end
      LOAD_WAIT: begin
        // A response arriving in the final wait cycle still beats the timeout.
        if (bus.Ld_valid) begin
          state_d   = IDLE;
          retired_d = retired_q + CNT_W'(1);
          if (wr_q) begin
            wen_d   = 1'b1;
            waddr_d = dest_q;
            wdata_d = bus.Ld_data;
          end
        end else if (cnt_q == WAIT_LAST) begin
          state_d   = IDLE;
          err_d     = 1'b1;
          retired_d = retired_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dest_q    <= '0;
      wr_q      <= 1'b0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dest_q    <= dest_d;
      wr_q      <= wr_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  assign bus.In_ready = in_ready;
  assign bus.Wen      = wen_q;
  assign bus.Waddr    = waddr_q;
  assign bus.Wdata    = wdata_q;
  assign bus.Ld_err   = err_q;
  assign bus.Retired  = retired_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: directed vector table, hand-written load/timeout/reset
// sequences, then a randomized stream checked against a transaction-level model.
module tb_wb_unit;
  import mips_pkg::*;

  logic clk;
  logic rst_n;

  wb_unit_if #(.CNT_W(16)) bus ();

  wb_unit #(.LD_TIMEOUT(16), .CNT_W(16)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  task automatic model_decode(input logic [31:0] ins, output bit wr, output bit ld,
                              output logic [4:0] d);
    logic [5:0] op;
    op = ins[31:26];
    wr = 1'b0;
    ld = 1'b0;
    d  = 5'd0;
    if (op == 6'h00) begin
      d = ins[15:11];
    end else if (op == 6'h08 || op == 6'h09 || op == 6'h0C || op == 6'h0D ||
                 op == 6'h0E || op == 6'h0A || op == 6'h0F || op == 6'h23) begin
      d = ins[20:16];
    end
    ld = (op == 6'h23);
    wr = (d != 5'd0);
  endtask

  // ---------------- scoreboard ----------------
  logic [36:0] exp_q[$];
  bit          mon_en;
  int          err_seen;
  int          exp_err;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.Wen === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL rand_unexpected_wen: got addr %0d data 0x%0h expected no write",
                   bus.Waddr, bus.Wdata);
        end else begin
          check("rand_write", {27'd0, bus.Waddr, bus.Wdata}, {27'd0, exp_q.pop_front()});
        end
      end
      if (bus.Ld_err === 1'b1) err_seen++;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] ins;
    logic [31:0] alu;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[14];

  logic [5:0] ops[13];

  initial begin
    int          exp_retired;
    int          cyc;
    bit          flag_wen;
    bit          flag_err;
    bit          wr;
    bit          ld;
    bit          delivered;
    logic [4:0]  d;
    logic [31:0] ins;
    logic [31:0] alu;
    int          lat;

    n_vec = 0; n_fail = 0; mon_en = 0; err_seen = 0; exp_err = 0;

    vecs[0]  = '{32'h34010005, 32'h00000005, 1'b1, 5'd1,  32'h00000005};
    vecs[1]  = '{32'h00221820, 32'h00000008, 1'b1, 5'd3,  32'h00000008};
    vecs[2]  = '{32'h20220064, 32'h00000069, 1'b1, 5'd2,  32'h00000069};
    vecs[3]  = '{32'hAC220008, 32'h00000123, 1'b0, 5'd2,  32'h00000069};
    vecs[4]  = '{32'h10220010, 32'h00000456, 1'b0, 5'd2,  32'h00000069};
    vecs[5]  = '{32'h08000400, 32'h00000789, 1'b0, 5'd2,  32'h00000069};
    vecs[6]  = '{32'h34000007, 32'h00000007, 1'b0, 5'd2,  32'h00000069};
    vecs[7]  = '{32'h3C1F1234, 32'h12340000, 1'b1, 5'd31, 32'h12340000};
    vecs[8]  = '{32'h2BE50001, 32'h00000001, 1'b1, 5'd5,  32'h00000001};
    vecs[9]  = '{32'h3885FFFF, 32'h0000ABCD, 1'b1, 5'd5,  32'h0000ABCD};
    vecs[10] = '{32'h30A6000F, 32'h0000000F, 1'b1, 5'd6,  32'h0000000F};
    vecs[11] = '{32'h24C70003, 32'h00000010, 1'b1, 5'd7,  32'h00000010};
    vecs[12] = '{32'h00220020, 32'hFFFFFFFF, 1'b0, 5'd7,  32'h00000010};
    vecs[13] = '{32'h14220003, 32'h00000055, 1'b0, 5'd7,  32'h00000010};

    ops = '{6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0F,
            6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};

    // ---- reset ----
    rst_n = 1'b0;
    bus.In_valid = 1'b0; bus.Ins = '0; bus.Alu_res = '0;
    bus.Ld_valid = 1'b0; bus.Ld_data = '0;
    step(); step();
    check("rst_wen",      bus.Wen,      0);
    check("rst_waddr",    bus.Waddr,    0);
    check("rst_wdata",    bus.Wdata,    0);
    check("rst_ld_err",   bus.Ld_err,   0);
    check("rst_retired",  bus.Retired,  0);
    check("rst_in_ready", bus.In_ready, 0);
    check("rst_state",    bus.state,    IDLE);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", bus.In_ready, 1);

    // ---- table: back-to-back non-load instructions ----
    exp_retired = 0;
    for (int i = 0; i < 14; i++) begin
      check("tbl_in_ready", bus.In_ready, 1);
      bus.In_valid = 1'b1;
      bus.Ins      = vecs[i].ins;
      bus.Alu_res  = vecs[i].alu;
      step();
      exp_retired++;
      check("tbl_wen",     bus.Wen,     vecs[i].wen);
      check("tbl_waddr",   bus.Waddr,   vecs[i].waddr);
      check("tbl_wdata",   bus.Wdata,   vecs[i].wdata);
      check("tbl_ld_err",  bus.Ld_err,  0);
      check("tbl_retired", bus.Retired, exp_retired);
    end
    bus.In_valid = 1'b0;
    // a register write from the last writing vector must not repeat
    step();
    check("tbl_idle_wen", bus.Wen, 0);

    // ---- lw with data after 3 wait cycles (accept-cycle Ld_valid ignored) ----
    bus.In_valid = 1'b1; bus.Ins = 32'h8C220004; bus.Alu_res = 32'h00000004;
    bus.Ld_valid = 1'b1; bus.Ld_data = 32'hBAD0BAD0;
    step();
    bus.In_valid = 1'b0; bus.Ld_valid = 1'b0;
    for (int w = 0; w < 4; w++) begin
      check("lw_wait_ready", bus.In_ready, 0);
      check("lw_wait_wen",   bus.Wen,      0);
      if (w == 3) begin
        bus.Ld_valid = 1'b1; bus.Ld_data = 32'h12345678;
      end
      step();
    end
    bus.Ld_valid = 1'b0;
    exp_retired++;
    check("lw_wen",      bus.Wen,      1);
    check("lw_waddr",    bus.Waddr,    2);
    check("lw_wdata",    bus.Wdata,    32'h12345678);
    check("lw_ready",    bus.In_ready, 1);
    check("lw_retired",  bus.Retired,  exp_retired);
    step();
    check("lw_wen_pulse", bus.Wen, 0);

    // ---- lw timeout ----
    bus.In_valid = 1'b1; bus.Ins = 32'h8C230000; bus.Alu_res = '0;
    step();
    bus.In_valid = 1'b0;
    cyc = 0; flag_wen = 0;
    while (cyc < 40 && bus.Ld_err !== 1'b1) begin
      if (bus.Wen === 1'b1) flag_wen = 1;
      step();
      cyc++;
    end
    exp_retired++;
    check("to_cycles",  cyc,         16);
    check("to_no_wen",  flag_wen,    0);
    check("to_wen_now", bus.Wen,     0);
    check("to_ready",   bus.In_ready, 1);
    check("to_retired", bus.Retired, exp_retired);
    check("to_waddr_held", bus.Waddr, 2);
    step();
    check("to_err_pulse", bus.Ld_err, 0);

    // ---- reset in the middle of LOAD_WAIT ----
    bus.In_valid = 1'b1; bus.Ins = 32'h8C240000; bus.Alu_res = '0;
    step();
    bus.In_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready",   bus.In_ready, 0);
    check("mid_rst_retired", bus.Retired,  0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.Ld_valid = 1'b1; bus.Ld_data = 32'hDEADBEEF;
    step();
    bus.Ld_valid = 1'b0;
    check("mid_rst_wen",     bus.Wen,      0);
    check("mid_rst_err",     bus.Ld_err,   0);
    check("mid_rst_retired2", bus.Retired, 0);
    check("mid_rst_ready2",  bus.In_ready, 1);
    flag_wen = 0; flag_err = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.Wen === 1'b1) flag_wen = 1;
      if (bus.Ld_err === 1'b1) flag_err = 1;
    end
    check("mid_rst_late_wen", flag_wen, 0);
    check("mid_rst_late_err", flag_err, 0);

    // ---- randomized stream against the model ----
    exp_retired = 0;
    mon_en = 1;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.Ld_valid = 1'($urandom_range(0, 1));
        bus.Ld_data  = $urandom;
        step();
      end
      bus.Ld_valid = 1'($urandom_range(0, 1));
      bus.Ld_data  = $urandom;
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 12)];
      alu = $urandom;
      model_decode(ins, wr, ld, d);
      check("rand_ready", bus.In_ready, 1);
      bus.In_valid = 1'b1; bus.Ins = ins; bus.Alu_res = alu;
      if (!ld) begin
        exp_retired++;
        if (wr) exp_q.push_back({d, alu});
      end
      step();
      bus.In_valid = 1'b0; bus.Ld_valid = 1'b0;
      if (ld) begin
        lat = $urandom_range(0, 19);
        delivered = 0;
        for (int w = 0; w < 16 && !delivered; w++) begin
          check("rand_wait_ready", bus.In_ready, 0);
          if (w == lat) begin
            bus.Ld_valid = 1'b1;
            bus.Ld_data  = $urandom;
            if (wr) exp_q.push_back({d, bus.Ld_data});
            delivered = 1;
          end
          step();
          bus.Ld_valid = 1'b0;
        end
        if (!delivered) exp_err++;
        exp_retired++;
      end
    end
    step(); step();
    mon_en = 0;
    check("rand_queue_drained", exp_q.size(), 0);
    check("rand_ld_err_count",  err_seen,     exp_err);
    check("rand_retired",       bus.Retired,  exp_retired[15:0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
